// File: rtl/hs_deserializer.sv
// hs_deserializer: HS lane receive deserializer.
// Takes the DDR two-bit-per-clock lane stream (Serial_B1 earlier, Serial_B2
// later), hunts for the sync byte at either bit alignment, then assembles
// LSB-first bytes and strobes them out with a one-cycle RX_VALID. Every
// output is registered; the output comb process computes their next values.
`timescale 1ns/1ps

module hs_deserializer #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
    parameter int unsigned SYNC_TIMEOUT = 64
) (
    input  logic       DDR_clk,
    input  logic       Rx_rst_n,
    input  logic       des_en,
    input  logic       Serial_B1,
    input  logic       Serial_B2,
    output logic [7:0] RX_BYTE_DATA,
    output logic       RX_VALID,
    output logic       RX_SYNC_HS,
    output logic       RX_ACTIVE,
    output logic       RX_ERR_SYNC
);

    localparam logic [15:0] TMO_LIMIT = SYNC_TIMEOUT[15:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        RECEIVE = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] sr;
    logic [1:0]  phase;
    logic [15:0] tmo_cnt;
    logic        align;

    logic [7:0]  win_even;
    logic [7:0]  win_odd;
    logic        hit_even;
    logic        hit_odd;

    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        sync_nxt;
    logic        active_nxt;
    logic        err_nxt;

    // The timeout counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Newest pair lands at the top of sr, so the even window holds a byte
    // ending on Serial_B2 and the odd window a byte ending on Serial_B1.
    assign win_even = sr[15:8];
    assign win_odd  = sr[14:7];
    assign hit_even = (win_even == SYNC_BYTE);
    assign hit_odd  = (win_odd == SYNC_BYTE);

    // State register.
    always_ff @(posedge DDR_clk or negedge Rx_rst_n) begin
        if (!Rx_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping des_en always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (!des_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = HUNT;
                HUNT: begin
                    if (hit_even || hit_odd) begin
                        state_nxt = RECEIVE;
                    end else if (sat_inc(tmo_cnt) == TMO_LIMIT) begin
                        state_nxt = ERROR;
                    end
                end
                RECEIVE: state_nxt = RECEIVE;
                ERROR:   state_nxt = ERROR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shift register, timeout counter, byte phase and alignment bookkeeping.
    always_ff @(posedge DDR_clk or negedge Rx_rst_n) begin
        if (!Rx_rst_n) begin
            sr      <= '0;
            phase   <= '0;
            tmo_cnt <= '0;
            align   <= 1'b0;
        end else if (!des_en) begin
            sr      <= '0;
            phase   <= '0;
            tmo_cnt <= '0;
            align   <= 1'b0;
        end else begin
            sr <= {Serial_B2, Serial_B1, sr[15:2]};
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    phase   <= '0;
                end
                HUNT: begin
                    if (hit_even) begin
                        align <= 1'b0;
                        phase <= '0;
                    end else if (hit_odd) begin
                        align <= 1'b1;
                        phase <= '0;
                    end else begin
                        tmo_cnt <= sat_inc(tmo_cnt);
                    end
                end
                RECEIVE: phase <= phase + 2'd1;
                default: ;
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        data_nxt   = RX_BYTE_DATA;
        valid_nxt  = 1'b0;
        sync_nxt   = 1'b0;
        if (des_en && (state == RECEIVE) && (phase == 2'd3)) begin
            valid_nxt = 1'b1;
            data_nxt  = align ? win_odd : win_even;
        end
        if (des_en && (state == HUNT) && (hit_even || hit_odd)) begin
            sync_nxt = 1'b1;
        end
        active_nxt = (state_nxt == RECEIVE);
        err_nxt    = (state_nxt == ERROR);
    end

    // Output registers; RX_BYTE_DATA only changes on a byte strobe.
    always_ff @(posedge DDR_clk or negedge Rx_rst_n) begin
        if (!Rx_rst_n) begin
            RX_BYTE_DATA <= 8'h00;
            RX_VALID     <= 1'b0;
            RX_SYNC_HS   <= 1'b0;
            RX_ACTIVE    <= 1'b0;
            RX_ERR_SYNC  <= 1'b0;
        end else begin
            RX_BYTE_DATA <= data_nxt;
            RX_VALID     <= valid_nxt;
            RX_SYNC_HS   <= sync_nxt;
            RX_ACTIVE    <= active_nxt;
            RX_ERR_SYNC  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_hs_deserializer.sv
// Testbench for hs_deserializer: directed DDR bit streams, expected strobes
// queued at stimulus time and popped by an independent negedge monitor.
`timescale 1ns/1ps

module tb_hs_deserializer;

    logic       DDR_clk   = 1'b0;
    logic       Rx_rst_n  = 1'b0;
    logic       des_en    = 1'b0;
    logic       Serial_B1 = 1'b0;
    logic       Serial_B2 = 1'b0;

    logic [7:0] RX_BYTE_DATA;
    logic       RX_VALID;
    logic       RX_SYNC_HS;
    logic       RX_ACTIVE;
    logic       RX_ERR_SYNC;

    logic [7:0] t_byte_data;
    logic       t_valid;
    logic       t_sync_hs;
    logic       t_active;
    logic       t_err_sync;

    always #5 DDR_clk = ~DDR_clk;

    hs_deserializer dut (
        .DDR_clk     (DDR_clk),
        .Rx_rst_n    (Rx_rst_n),
        .des_en      (des_en),
        .Serial_B1   (Serial_B1),
        .Serial_B2   (Serial_B2),
        .RX_BYTE_DATA(RX_BYTE_DATA),
        .RX_VALID    (RX_VALID),
        .RX_SYNC_HS  (RX_SYNC_HS),
        .RX_ACTIVE   (RX_ACTIVE),
        .RX_ERR_SYNC (RX_ERR_SYNC)
    );

    // Short-timeout instance for the sync error scenario.
    hs_deserializer #(.SYNC_TIMEOUT(8)) dut_t (
        .DDR_clk     (DDR_clk),
        .Rx_rst_n    (Rx_rst_n),
        .des_en      (des_en),
        .Serial_B1   (Serial_B1),
        .Serial_B2   (Serial_B2),
        .RX_BYTE_DATA(t_byte_data),
        .RX_VALID    (t_valid),
        .RX_SYNC_HS  (t_sync_hs),
        .RX_ACTIVE   (t_active),
        .RX_ERR_SYNC (t_err_sync)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge DDR_clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_sync;
        logic [7:0] data;
        int         at;
    } exp_t;

    typedef struct {
        int         last;
        bit         is_sync;
        logic [7:0] data;
    } mark_t;

    exp_t  sb[$];
    bit    sbits[$];
    mark_t marks[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge DDR_clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL sb_missed: no strobe at cycle %0d, expected sync=%0d data 0x%0h",
                     e.at, e.is_sync, e.data);
        end
        if (RX_VALID || RX_SYNC_HS) begin
            if (sb.size() > 0 && sb[0].at == cyc) begin
                e = sb.pop_front();
                chk("sb_kind_sync", 32'(RX_SYNC_HS), 32'(e.is_sync));
                chk("sb_kind_valid", 32'(RX_VALID), 32'(!e.is_sync));
                if (!e.is_sync) chk("sb_data", 32'(RX_BYTE_DATA), 32'(e.data));
            end else begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: strobe valid=%0d sync=%0d data 0x%0h at cycle %0d, none expected",
                         RX_VALID, RX_SYNC_HS, RX_BYTE_DATA, cyc);
            end
        end
    end

    task automatic put_zeros(input int n);
        repeat (n) sbits.push_back(1'b0);
    endtask

    task automatic put_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) sbits.push_back(v[i]);
    endtask

    task automatic put_byte(input logic [7:0] v, input bit is_sync);
        put_bits(v, 8);
        marks.push_back('{sbits.size() - 1, is_sync, v});
    endtask

    // Called at a negedge; drives one pair per cycle with des_en high and
    // queues a strobe one edge after each marked last bit is sampled.
    task automatic play();
        if (sbits.size() % 2 != 0) sbits.push_back(1'b0);
        for (int p = 0; p < sbits.size() / 2; p++) begin
            des_en    = 1'b1;
            Serial_B1 = sbits[2*p];
            Serial_B2 = sbits[2*p+1];
            foreach (marks[i]) begin
                if (marks[i].last / 2 == p) sb.push_back('{marks[i].is_sync, marks[i].data, cyc + 2});
            end
            @(negedge DDR_clk);
        end
        sbits.delete();
        marks.delete();
    endtask

    // Called at a negedge; lowers des_en for exactly one edge.
    task automatic stop_session(input string tag);
        chk({tag, "_active_before_drop"}, 32'(RX_ACTIVE), 32'd1);
        des_en    = 1'b0;
        Serial_B1 = 1'b0;
        Serial_B2 = 1'b0;
        @(negedge DDR_clk);
        chk({tag, "_active_after_drop"}, 32'(RX_ACTIVE), 32'd0);
        chk({tag, "_err_after_drop"}, 32'(RX_ERR_SYNC), 32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e0;

        // Reset state
        repeat (2) @(negedge DDR_clk);
        chk("rst_data", 32'(RX_BYTE_DATA), 32'h00);
        chk("rst_valid", 32'(RX_VALID), 32'd0);
        chk("rst_sync", 32'(RX_SYNC_HS), 32'd0);
        chk("rst_active", 32'(RX_ACTIVE), 32'd0);
        chk("rst_err", 32'(RX_ERR_SYNC), 32'd0);
        #2 Rx_rst_n = 1'b1;
        @(negedge DDR_clk);

        // 1: even-aligned sync
        put_zeros(16);
        put_byte(8'hB8, 1'b1);
        put_byte(8'h55, 1'b0);
        put_byte(8'hA3, 1'b0);
        put_byte(8'h0F, 1'b0);
        put_zeros(2);
        play();
        stop_session("s1");
        chk("s1_data_hold", 32'(RX_BYTE_DATA), 32'h0F);

        // 2: odd-aligned sync (one extra leading bit)
        put_zeros(17);
        put_byte(8'hB8, 1'b1);
        put_byte(8'h55, 1'b0);
        put_byte(8'hA3, 1'b0);
        put_byte(8'h0F, 1'b0);
        put_zeros(2);
        play();
        stop_session("s2");

        // 3: sync timeout on the short-timeout instance, then relock
        e0 = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            des_en    = 1'b1;
            Serial_B1 = 1'b0;
            Serial_B2 = 1'b0;
            @(negedge DDR_clk);
            chk($sformatf("s3_err_edge%0d", cyc - e0), 32'(t_err_sync), 32'(i >= 8));
            chk($sformatf("s3_no_valid_edge%0d", cyc - e0), 32'(t_valid), 32'd0);
        end
        chk("s3_main_no_err", 32'(RX_ERR_SYNC), 32'd0);
        chk("s3_main_not_active", 32'(RX_ACTIVE), 32'd0);
        des_en = 1'b0;
        @(negedge DDR_clk);
        chk("s3_err_cleared", 32'(t_err_sync), 32'd0);
        put_byte(8'hB8, 1'b1);
        put_byte(8'h66, 1'b0);
        put_zeros(2);
        play();
        chk("s3_relock_active", 32'(t_active), 32'd1);
        chk("s3_relock_data", 32'(t_byte_data), 32'h66);
        stop_session("s3");

        // 4: sync pattern inside payload, des_en dropped mid-byte
        put_zeros(16);
        put_byte(8'hB8, 1'b1);
        put_byte(8'hB8, 1'b0);
        put_byte(8'h12, 1'b0);
        put_bits(8'hFF, 4);
        play();
        stop_session("s4");
        chk("s4_data_hold", 32'(RX_BYTE_DATA), 32'h12);

        // 5: asynchronous reset mid-byte
        put_zeros(8);
        put_byte(8'hB8, 1'b1);
        put_bits(8'h5A, 4);
        play();
        #2 Rx_rst_n = 1'b0;
        des_en    = 1'b0;
        Serial_B1 = 1'b0;
        Serial_B2 = 1'b0;
        #1;
        chk("s5_rst_data", 32'(RX_BYTE_DATA), 32'h00);
        chk("s5_rst_active", 32'(RX_ACTIVE), 32'd0);
        chk("s5_rst_valid", 32'(RX_VALID), 32'd0);
        chk("s5_rst_sync", 32'(RX_SYNC_HS), 32'd0);
        chk("s5_rst_err", 32'(RX_ERR_SYNC), 32'd0);
        @(posedge DDR_clk);
        #3 Rx_rst_n = 1'b1;
        @(negedge DDR_clk);
        chk("s5_idle_after_release", 32'(RX_ACTIVE), 32'd0);
        put_zeros(8);
        put_bits(8'h5A, 8);
        put_byte(8'hB8, 1'b1);
        put_byte(8'h3C, 1'b0);
        put_zeros(2);
        play();
        stop_session("s5");
        chk("s5_data_hold", 32'(RX_BYTE_DATA), 32'h3C);

        // 6: back-to-back sessions, even then odd alignment
        put_zeros(8);
        put_byte(8'hB8, 1'b1);
        put_byte(8'h96, 1'b0);
        put_zeros(2);
        play();
        stop_session("s6a");
        chk("s6a_data_hold", 32'(RX_BYTE_DATA), 32'h96);
        put_zeros(9);
        put_byte(8'hB8, 1'b1);
        put_byte(8'hC5, 1'b0);
        put_byte(8'h81, 1'b0);
        put_zeros(2);
        play();
        stop_session("s6b");
        chk("s6b_data_hold", 32'(RX_BYTE_DATA), 32'h81);

        repeat (3) @(negedge DDR_clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
